pc_fetch_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch for the RISC-V core.

---
 rtl/pc_fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Purpose: owns the PC and runs one IMEM fetch at a time, handing each word to decode.
// Latency: REQ -> WAIT -> HOLD, so at best 3 cycles per instruction with a zero-wait IMEM.
// Backpressure: waits in REQ until imem_ready and in HOLD until dec_ready; no request while holding.
//
// Ports:
//   clk, rst_n                     core clock (rising edge), async active-low reset
//   imem_req/imem_addr/imem_ready  fetch request, address (= pc in REQ, else 0), accept
//   imem_rvalid/imem_rdata         fetch response, honoured only in WAIT
//   instr_valid/instr/instr_pc     registered instruction handed to decode
//   dec_ready                      decode consumes instr this cycle
//   redirect_en/redirect_target    taken branch/jump, highest priority in every state
//   halt_req/halted                halt at the next instruction boundary / sequencer parked
//   trap_valid                     1-cycle pulse on a misaligned redirect target
// Build option: define PC_MISALIGN_TRAP_EN to trap misaligned targets to TRAP_VECTOR;
// otherwise the target's low two bits are cleared and trap_valid stays 0.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        dec_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        halted,
  output logic        trap_valid
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc;
  logic        squash;     // an accepted fetch is stale; drop its response
  logic        halt_pend;  // halt requested, not yet taken
  logic        halt_any;
  logic        redir_trap;
  logic [31:0] redir_pc;

  // Pending halt or one arriving this very cycle both stop at this boundary.
  assign halt_any = halt_pend | halt_req;

`ifdef PC_MISALIGN_TRAP_EN
  assign redir_trap = (redirect_target[1:0] != 2'b00);
`else
  logic [1:0] tgt_lo_unused;
  assign tgt_lo_unused = redirect_target[1:0];
  assign redir_trap    = 1'b0;
`endif

  // Without the trap option redir_trap is 0, so the low bits are simply cleared.
  assign redir_pc = redir_trap ? TRAP_VECTOR : {redirect_target[31:2], 2'b00};

  // Only the request side is decoded from state; everything else is registered.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = imem_req ? pc : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_VECTOR;
      squash      <= 1'b0;
      halt_pend   <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      halted      <= 1'b0;
      trap_valid  <= 1'b0;
    end else begin
      trap_valid <= redirect_en & redir_trap;
      if (halt_req) halt_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          state <= S_REQ;
          if (redirect_en) pc <= redir_pc;
        end

        S_REQ: begin
          if (redirect_en) begin
            pc <= redir_pc;
            // Accepted in the same cycle: the old address is in flight, drop its data.
            if (imem_ready) begin
              squash <= 1'b1;
              state  <= S_WAIT;
            end
          end else if (imem_ready) begin
            state <= S_WAIT;
          end else if (halt_any) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            halt_pend <= 1'b0;
          end
        end

        S_WAIT: begin
          if (redirect_en) pc <= redir_pc;
          if (imem_rvalid) begin
            // A redirect arriving with the response makes that response stale too.
            if (squash || redirect_en) begin
              squash <= 1'b0;
              state  <= S_REQ;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end
          end else if (redirect_en) begin
            squash <= 1'b1;
          end
        end

        S_HOLD: begin
          if (redirect_en) begin
            // Redirect wins over consumption: the held word is discarded, no pc+4.
            instr_valid <= 1'b0;
            pc          <= redir_pc;
            state       <= S_REQ;
          end else if (dec_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc + 32'd4;
            if (halt_any) begin
              state     <= S_HALT;
              halted    <= 1'b1;
              halt_pend <= 1'b0;
            end else begin
              state <= S_REQ;
            end
          end
        end

        S_HALT: begin
          if (redirect_en) begin
            pc     <= redir_pc;
            halted <= 1'b0;
            state  <= S_REQ;
          end else begin
            halt_pend <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  localparam logic [31:0] TRAP_PC = 32'h0000_0010;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready;
  logic        redirect_en;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        halted;
  logic        trap_valid;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .dec_ready(dec_ready), .redirect_en(redirect_en), .redirect_target(redirect_target),
    .halt_req(halt_req), .halted(halted), .trap_valid(trap_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // IMEM responder: one outstanding fetch, latency lat_min..lat_max cycles after accept.
  bit          pend_v = 1'b0;
  logic [31:0] pend_a = 32'h0;
  int          pend_cnt = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  task automatic drive_imem();
    imem_rvalid = pend_v && (pend_cnt == 0);
    imem_rdata  = imem_rvalid ? imem_word(pend_a) : 32'hDEAD_BEEF;
  endtask

  // Called at a negedge with inputs set; advances one clock and returns at the next negedge.
  task automatic cycle();
    logic        acc;
    logic [31:0] acc_a;
    drive_imem();
    acc   = imem_req && imem_ready;
    acc_a = imem_addr;
    @(posedge clk);
    @(negedge clk);
    if (imem_rvalid) pend_v = 1'b0;
    else if (pend_v) pend_cnt--;
    if (acc) begin
      pend_v   = 1'b1;
      pend_a   = acc_a;
      pend_cnt = $urandom_range(lat_max - 1, lat_min - 1);
    end
    drive_imem();
  endtask

  task automatic set_in(input logic dr, input logic rdy, input logic rd,
                        input logic hr, input logic [31:0] tgt);
    dec_ready       = dr;
    imem_ready      = rdy;
    redirect_en     = rd;
    halt_req        = hr;
    redirect_target = tgt;
  endtask

  typedef struct {
    logic        dr, rdy, rd, hr;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic        e_halted, e_trap;
  } vec_t;

  function automatic vec_t v(input logic dr, input logic rdy, input logic rd, input logic hr,
                             input logic [31:0] tgt, input logic e_req, input logic [31:0] e_addr,
                             input logic e_iv, input logic [31:0] e_ipc,
                             input logic e_halted, input logic e_trap);
    vec_t r;
    r.dr = dr; r.rdy = rdy; r.rd = rd; r.hr = hr; r.tgt = tgt;
    r.e_req = e_req; r.e_addr = e_addr; r.e_iv = e_iv; r.e_ipc = e_ipc;
    r.e_halted = e_halted; r.e_trap = e_trap;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[35];
    logic [31:0] mis_addr;
    logic        mis_trap;
    logic [31:0] exp_pc;
    logic        exp_trap;
    logic        nxt_trap;
    logic        rd;
    logic [31:0] tgt;
    int          n_deliv;

    mis_addr = TRAP_EN ? TRAP_PC : 32'h0000_0100;
    mis_trap = TRAP_EN;

    // Each row: expected outputs at this cycle, then inputs applied for this cycle.
    //            dr rdy rd hr tgt           req addr          iv ipc           hlt trap
    tbl[0]  = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
    tbl[1]  = v(1, 1, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 0);
    tbl[2]  = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
    tbl[3]  = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0);
    tbl[4]  = v(1, 1, 0, 0, 32'h0,         1, 32'h4,         0, 32'h0,         0, 0);
    tbl[5]  = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
    tbl[6]  = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         0, 0);
    tbl[7]  = v(1, 1, 0, 0, 32'h0,         1, 32'h8,         0, 32'h0,         0, 0);
    tbl[8]  = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
    tbl[9]  = v(0, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 0);
    tbl[10] = v(0, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 0);
    tbl[11] = v(0, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 0);
    tbl[12] = v(0, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 0);
    tbl[13] = v(0, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 0);
    tbl[14] = v(1, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 0);
    tbl[15] = v(1, 0, 0, 1, 32'h0,         1, 32'hC,         0, 32'h0,         0, 0);
    tbl[16] = v(1, 1, 1, 0, 32'h80,        0, 32'h0,         0, 32'h0,         1, 0);
    tbl[17] = v(1, 1, 0, 0, 32'h0,         1, 32'h80,        0, 32'h0,         0, 0);
    tbl[18] = v(1, 1, 1, 0, 32'h100,       0, 32'h0,         0, 32'h0,         0, 0);
    tbl[19] = v(1, 1, 0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         0, 0);
    tbl[20] = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
    tbl[21] = v(1, 1, 1, 0, 32'h40,        0, 32'h0,         1, 32'h100,       0, 0);
    tbl[22] = v(1, 1, 0, 0, 32'h0,         1, 32'h40,        0, 32'h0,         0, 0);
    tbl[23] = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
    tbl[24] = v(1, 0, 1, 0, 32'h200,       0, 32'h0,         1, 32'h40,        0, 0);
    tbl[25] = v(1, 0, 1, 0, 32'h102,       1, 32'h200,       0, 32'h0,         0, 0);
    tbl[26] = v(1, 0, 0, 0, 32'h0,         1, mis_addr,      0, 32'h0,         0, mis_trap);
    tbl[27] = v(1, 0, 1, 0, 32'hFFFF_FFFC, 1, mis_addr,      0, 32'h0,         0, 0);
    tbl[28] = v(1, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         0, 0);
    tbl[29] = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
    tbl[30] = v(1, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0);
    tbl[31] = v(1, 0, 1, 1, 32'h300,       1, 32'h0,         0, 32'h0,         0, 0);
    tbl[32] = v(1, 0, 0, 0, 32'h0,         1, 32'h300,       0, 32'h0,         0, 0);
    tbl[33] = v(1, 0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 0);
    tbl[34] = v(1, 0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 0);

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 32'h0);
    drive_imem();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;

    // ---- table-driven directed sequence ----
    for (int i = 0; i < 35; i++) begin
      chk($sformatf("row%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_ivalid", i), {31'h0, instr_valid}, {31'h0, tbl[i].e_iv});
      if (tbl[i].e_iv) begin
        chk($sformatf("row%0d_ipc", i), instr_pc, tbl[i].e_ipc);
        chk($sformatf("row%0d_instr", i), instr, imem_word(tbl[i].e_ipc));
      end
      chk($sformatf("row%0d_halted", i), {31'h0, halted}, {31'h0, tbl[i].e_halted});
      chk($sformatf("row%0d_trap", i), {31'h0, trap_valid}, {31'h0, tbl[i].e_trap});
      set_in(tbl[i].dr, tbl[i].rdy, tbl[i].rd, tbl[i].hr, tbl[i].tgt);
      cycle();
    end

    // ---- redirect in WAIT before a slow response: response must be dropped ----
    lat_min = 3; lat_max = 3;
    set_in(1, 1, 0, 0, 32'h0);
    cycle();
    set_in(1, 0, 1, 0, 32'h500);
    cycle();
    set_in(1, 0, 0, 0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (imem_req) break;
      chk("squash_ivalid", {31'h0, instr_valid}, 32'h0);
      cycle();
    end
    chk("squash_req", {31'h0, imem_req}, 32'h1);
    chk("squash_addr", imem_addr, 32'h500);

    // ---- reset asserted during WAIT: outputs clear at once, late response ignored ----
    set_in(1, 1, 0, 0, 32'h0);
    cycle();
    set_in(1, 0, 0, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_ivalid", {31'h0, instr_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_ipc", instr_pc, 32'h0);
    chk("arst_halted", {31'h0, halted}, 32'h0);
    chk("arst_trap", {31'h0, trap_valid}, 32'h0);
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("stale_ivalid", {31'h0, instr_valid}, 32'h0);
    end
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    lat_min = 1; lat_max = 1;
    set_in(0, 1, 0, 0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (instr_valid) break;
      cycle();
    end
    chk("post_rst_ivalid", {31'h0, instr_valid}, 32'h1);
    chk("post_rst_ipc", instr_pc, 32'h0);

    // ---- randomized run against an instruction-stream model ----
    // exp_pc is the address of the next instruction decode should receive.
    exp_pc   = 32'h0;
    exp_trap = 1'b0;
    n_deliv  = 0;
    lat_min  = 1;
    lat_max  = 3;
    for (int c = 0; c < 3000; c++) begin
      rd  = halted ? ($urandom_range(1, 0) == 1) : ($urandom_range(99, 0) < 4);
      tgt = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_0FFF);
      set_in($urandom_range(9, 0) < 6, $urandom_range(9, 0) < 7, rd,
             !halted && ($urandom_range(99, 0) < 3), tgt);

      chk("rnd_trap", {31'h0, trap_valid}, {31'h0, exp_trap});
      if (imem_req) chk("rnd_addr", imem_addr, exp_pc);
      if (halted) chk("rnd_halt_noreq", {31'h0, imem_req}, 32'h0);
      if (instr_valid) chk("rnd_instr", instr, imem_word(instr_pc));

      nxt_trap = 1'b0;
      if (rd) begin
        if (TRAP_EN && tgt[1:0] != 2'b00) begin
          exp_pc   = TRAP_PC;
          nxt_trap = 1'b1;
        end else begin
          exp_pc = {tgt[31:2], 2'b00};
        end
      end else if (instr_valid && dec_ready) begin
        chk("rnd_ipc", instr_pc, exp_pc);
        exp_pc  = exp_pc + 32'd4;
        n_deliv++;
      end
      cycle();
      exp_trap = nxt_trap;
    end
    chk("rnd_progress", {31'h0, n_deliv >= 100}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
